// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that funnels host bytes into per-channel FIFOs and
// dispatches each FIFO to its UART transmitter, pacing on tx_busy.
module uart_tx_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int NUM_CH   = 2,
  parameter  int DEPTH    = 4,
  parameter  int START_TO = 16,
  localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [CHW*NUM_REQ-1:0] req_ch,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_CH-1:0]      ch_enable,
  input  logic [NUM_CH-1:0]      tx_busy,
  output logic [NUM_CH-1:0]      tx_start,
  output logic [8*NUM_CH-1:0]    tx_data,
  output logic [NUM_CH-1:0]      ch_full,
  output logic                   drop_err,
  output logic [NUM_CH-1:0]      start_lost
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(NUM_REQ);
  localparam int TW = $clog2(START_TO + 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TO_C    = TW'(START_TO - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} state_e;

  logic [RW-1:0]             rr_q, rr_d;
  logic [NUM_CH-1:0][AW:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0][AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]                mem_q [NUM_CH][DEPTH];
  state_e                    st_q [NUM_CH];
  state_e                    st_d [NUM_CH];
  logic [NUM_CH-1:0][TW-1:0] tmr_q, tmr_d;
  logic [NUM_CH-1:0]         start_q, start_d, lost_q, lost_d;
  logic [NUM_CH-1:0][7:0]    data_q, data_d;
  logic                      drop_q, drop_d;

  logic [NUM_CH-1:0]  full, push, pop;
  logic [NUM_REQ-1:0] elig;
  logic               gnt_vld, gnt_in_rng;
  logic [RW-1:0]      gnt_idx;
  logic [7:0]         gnt_data;
  logic [CHW-1:0]     gnt_ch;

  // Eligibility uses the registered count, so a same-cycle pop never frees a slot.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    elig    = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) full[c] = (cnt_q[c] == DEPTH_C);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i];
      for (int unsigned c = 0; c < NUM_CH; c++)
        if (req_ch[i*CHW +: CHW] == CHW'(c) && full[c]) elig[i] = 1'b0;
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_q) + k) % NUM_REQ;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = RW'(idx);
      end
    end
  end

  always_comb begin
    gnt_data   = req_data[32'(gnt_idx)*8 +: 8];
    gnt_ch     = req_ch[32'(gnt_idx)*CHW +: CHW];
    req_ready  = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
    rr_d       = gnt_vld ? RW'((32'(gnt_idx) + 1) % NUM_REQ) : rr_q;
    gnt_in_rng = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      push[c] = gnt_vld && (gnt_ch == CHW'(c));
      if (gnt_ch == CHW'(c)) gnt_in_rng = 1'b1;
    end
    drop_d = gnt_vld && !gnt_in_rng;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      wr_d[c]  = wr_q[c] + AW'(push[c]);
      rd_d[c]  = rd_q[c] + AW'(pop[c]);
      cnt_d[c] = cnt_q[c] + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
    end
  end

  // Dispatcher next-state
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      st_d[c]  = st_q[c];
      tmr_d[c] = tmr_q[c];
      pop[c]   = 1'b0;
      case (st_q[c])
        S_IDLE:
          if (cnt_q[c] != '0 && ch_enable[c] && !tx_busy[c]) begin
            pop[c]   = 1'b1;
            st_d[c]  = S_WAIT_BUSY;
            tmr_d[c] = '0;
          end
        S_WAIT_BUSY:
          if (tx_busy[c])            st_d[c]  = S_WAIT_DONE;
          else if (tmr_q[c] == TO_C) st_d[c]  = S_IDLE;
          else                       tmr_d[c] = tmr_q[c] + 1'b1;
        S_WAIT_DONE:
          if (!tx_busy[c]) st_d[c] = S_IDLE;
        default: st_d[c] = S_IDLE;
      endcase
    end
  end

  // Dispatcher outputs
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      start_d[c] = pop[c];
      data_d[c]  = pop[c] ? mem_q[c][rd_q[c]] : data_q[c];
      lost_d[c]  = (st_q[c] == S_WAIT_BUSY) && !tx_busy[c] && (tmr_q[c] == TO_C);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q    <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      tmr_q   <= '0;
      start_q <= '0;
      lost_q  <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) st_q[c] <= S_IDLE;
    end else begin
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      tmr_q   <= tmr_d;
      start_q <= start_d;
      lost_q  <= lost_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
      for (int unsigned c = 0; c < NUM_CH; c++) st_q[c] <= st_d[c];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++)
      if (push[c]) mem_q[c][wr_q[c]] <= gnt_data;
  end

  assign tx_start   = start_q;
  assign tx_data    = data_q;
  assign ch_full    = full;
  assign drop_err   = drop_q;
  assign start_lost = lost_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle table plus hand-written sequences.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid, req_ready, req_ch;
  logic [31:0] req_data;
  logic [1:0]  ch_enable, tx_busy, tx_start, ch_full, start_lost;
  logic [15:0] tx_data;
  logic        drop_err;

  logic [3:0]  v3, rdy3;
  logic [31:0] d3;
  logic [7:0]  c3;
  logic [2:0]  en3, b3, st3, full3, lost3;
  logic [23:0] dat3;
  logic        drop3;

  int total = 0;
  int bad   = 0;
  int bcnt, nst, nlost;
  int st_cyc [4];
  int lost_cyc [4];
  logic [7:0] st_dat [4];

  typedef struct {
    logic        rst_n;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic [3:0]  rc;
    logic [1:0]  en;
    logic [1:0]  busy;
    logic [3:0]  e_rdy;
    logic [1:0]  e_st;
    logic [15:0] e_dat;
    logic [1:0]  e_full;
    logic [1:0]  e_lost;
  } vec_t;
  vec_t tbl [18];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .NUM_CH(2), .DEPTH(4), .START_TO(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ch(req_ch),
    .req_ready(req_ready), .ch_enable(ch_enable), .tx_busy(tx_busy), .tx_start(tx_start),
    .tx_data(tx_data), .ch_full(ch_full), .drop_err(drop_err), .start_lost(start_lost));

  uart_tx_arbiter #(.NUM_REQ(4), .NUM_CH(3), .DEPTH(4), .START_TO(16)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_data(d3), .req_ch(c3),
    .req_ready(rdy3), .ch_enable(en3), .tx_busy(b3), .tx_start(st3),
    .tx_data(dat3), .ch_full(full3), .drop_err(drop3), .start_lost(lost3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    req_valid = '0; req_data = '0; req_ch = '0; ch_enable = 2'b11; tx_busy = '0;
    v3 = '0; d3 = '0; c3 = '0; en3 = 3'b111; b3 = '0;
  endtask

  task automatic nextc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    //          rst  rv    rd            rc    en     busy    rdy   st     dat       full   lost
    tbl[0]  = '{1'b0, 4'h0, 32'h0,        4'h0, 2'b11, 2'b00, 4'h0, 2'b00, 16'h0000, 2'b00, 2'b00};
    tbl[1]  = '{1'b1, 4'h1, 32'h000000A5, 4'h1, 2'b11, 2'b00, 4'h1, 2'b00, 16'h0000, 2'b00, 2'b00};
    tbl[2]  = '{1'b1, 4'h0, 32'h0,        4'h0, 2'b11, 2'b00, 4'h0, 2'b00, 16'h0000, 2'b00, 2'b00};
    tbl[3]  = '{1'b1, 4'h0, 32'h0,        4'h0, 2'b11, 2'b00, 4'h0, 2'b10, 16'hA500, 2'b00, 2'b00};
    tbl[4]  = '{1'b1, 4'h0, 32'h0,        4'h0, 2'b11, 2'b10, 4'h0, 2'b00, 16'hA500, 2'b00, 2'b00};
    tbl[5]  = '{1'b1, 4'h0, 32'h0,        4'h0, 2'b11, 2'b00, 4'h0, 2'b00, 16'hA500, 2'b00, 2'b00};
    tbl[6]  = '{1'b0, 4'h0, 32'h0,        4'h0, 2'b11, 2'b00, 4'h0, 2'b00, 16'h0000, 2'b00, 2'b00};
    tbl[7]  = '{1'b1, 4'hF, 32'h44332211, 4'h0, 2'b11, 2'b11, 4'h1, 2'b00, 16'h0000, 2'b00, 2'b00};
    tbl[8]  = '{1'b1, 4'hF, 32'h44332211, 4'h0, 2'b11, 2'b11, 4'h2, 2'b00, 16'h0000, 2'b00, 2'b00};
    tbl[9]  = '{1'b1, 4'hF, 32'h44332211, 4'h0, 2'b11, 2'b11, 4'h4, 2'b00, 16'h0000, 2'b00, 2'b00};
    tbl[10] = '{1'b1, 4'hF, 32'h44332211, 4'h0, 2'b11, 2'b11, 4'h8, 2'b00, 16'h0000, 2'b00, 2'b00};
    tbl[11] = '{1'b1, 4'hF, 32'h44332211, 4'h0, 2'b11, 2'b11, 4'h0, 2'b00, 16'h0000, 2'b01, 2'b00};
    tbl[12] = '{1'b1, 4'hF, 32'h44332211, 4'h0, 2'b11, 2'b11, 4'h0, 2'b00, 16'h0000, 2'b01, 2'b00};
    tbl[13] = '{1'b1, 4'h6, 32'h00665500, 4'h4, 2'b11, 2'b11, 4'h4, 2'b00, 16'h0000, 2'b01, 2'b00};
    tbl[14] = '{1'b1, 4'h2, 32'h00665500, 4'h4, 2'b11, 2'b11, 4'h0, 2'b00, 16'h0000, 2'b01, 2'b00};
    tbl[15] = '{1'b1, 4'h2, 32'h00665500, 4'h4, 2'b11, 2'b10, 4'h0, 2'b00, 16'h0000, 2'b01, 2'b00};
    tbl[16] = '{1'b1, 4'h2, 32'h00665500, 4'h4, 2'b11, 2'b10, 4'h2, 2'b01, 16'h0011, 2'b00, 2'b00};
    tbl[17] = '{1'b1, 4'h0, 32'h0,        4'h0, 2'b11, 2'b10, 4'h0, 2'b00, 16'h0011, 2'b01, 2'b00};

    nextc();
    for (int r = 0; r < 18; r++) begin
      rst = tbl[r].rst_n; req_valid = tbl[r].rv; req_data = tbl[r].rd; req_ch = tbl[r].rc;
      ch_enable = tbl[r].en; tx_busy = tbl[r].busy;
      @(negedge clk);
      chk($sformatf("row%0d ready", r), 32'(req_ready),  32'(tbl[r].e_rdy));
      chk($sformatf("row%0d start", r), 32'(tx_start),   32'(tbl[r].e_st));
      chk($sformatf("row%0d data", r),  32'(tx_data),    32'(tbl[r].e_dat));
      chk($sformatf("row%0d full", r),  32'(ch_full),    32'(tbl[r].e_full));
      chk($sformatf("row%0d lost", r),  32'(start_lost), 32'(tbl[r].e_lost));
      nextc();
    end

    // Pacing: busy rises one cycle after each start and stays high for 10 cycles.
    do_reset();
    bcnt = 0; nst = 0; nlost = 0;
    for (int i = 0; i < 4; i++) begin st_cyc[i] = 0; st_dat[i] = '0; lost_cyc[i] = 0; end
    for (int k = 0; k < 80; k++) begin
      req_valid = (k < 3) ? 4'b0001 : 4'b0000;
      req_data  = (k < 3) ? 32'(17 * (k + 1)) : 32'h0;
      tx_busy[0] = (bcnt > 0);
      if (bcnt > 0) bcnt--;
      @(negedge clk);
      if (tx_start[0]) begin
        if (nst < 4) begin st_cyc[nst] = k; st_dat[nst] = tx_data[7:0]; end
        nst++;
        bcnt = 10;
      end
      if (start_lost[0]) nlost++;
      nextc();
    end
    chk("pace count", 32'(nst), 32'd3);
    chk("pace first cycle", 32'(st_cyc[0]), 32'd2);
    chk("pace gap1", 32'(st_cyc[1] - st_cyc[0]), 32'd13);
    chk("pace gap2", 32'(st_cyc[2] - st_cyc[1]), 32'd13);
    chk("pace byte0", 32'(st_dat[0]), 32'h11);
    chk("pace byte1", 32'(st_dat[1]), 32'h22);
    chk("pace byte2", 32'(st_dat[2]), 32'h33);
    chk("pace no lost", 32'(nlost), 32'd0);

    // Start lost: tx_busy never rises.
    do_reset();
    nst = 0; nlost = 0;
    for (int i = 0; i < 4; i++) begin st_cyc[i] = 0; st_dat[i] = '0; lost_cyc[i] = 0; end
    for (int k = 0; k < 60; k++) begin
      req_valid = (k < 2) ? 4'b0001 : 4'b0000;
      req_data  = (k == 0) ? 32'h5A : 32'h6B;
      @(negedge clk);
      if (tx_start[0]) begin
        if (nst < 4) begin st_cyc[nst] = k; st_dat[nst] = tx_data[7:0]; end
        nst++;
      end
      if (start_lost[0]) begin
        if (nlost < 4) lost_cyc[nlost] = k;
        nlost++;
      end
      nextc();
    end
    chk("lost starts", 32'(nst), 32'd2);
    chk("lost pulses", 32'(nlost), 32'd2);
    chk("lost first start", 32'(st_cyc[0]), 32'd2);
    chk("lost first pulse", 32'(lost_cyc[0]), 32'd18);
    chk("lost restart", 32'(st_cyc[1]), 32'd19);
    chk("lost restart byte", 32'(st_dat[1]), 32'h6B);
    chk("lost second pulse", 32'(lost_cyc[1]), 32'd35);

    // Enable gating, then async reset while in WAIT_DONE.
    do_reset();
    ch_enable = 2'b10;
    nst = 0;
    for (int k = 0; k < 20; k++) begin
      req_valid = (k < 2) ? 4'b0001 : 4'b0000;
      req_data  = (k == 0) ? 32'hC1 : 32'hC2;
      @(negedge clk);
      if (tx_start[0]) nst++;
      nextc();
    end
    chk("en off starts", 32'(nst), 32'd0);
    chk("en off full", 32'(ch_full), 32'd0);
    ch_enable = 2'b11; req_valid = '0;
    @(negedge clk);
    chk("en on same cycle", 32'(tx_start), 32'd0);
    nextc();
    @(negedge clk);
    chk("en on start", 32'(tx_start), 32'd1);
    chk("en on data", 32'(tx_data[7:0]), 32'hC1);
    nextc();
    tx_busy = 2'b01;
    for (int j = 0; j < 3; j++) begin
      req_valid = 4'b0001;
      req_data  = 32'(8'hD1 + j);
      @(negedge clk);
      nextc();
    end
    req_valid = '0;
    @(negedge clk);
    chk("wait_done full", 32'(ch_full), 32'd1);
    nextc();
    rst = 1'b0;
    #1;
    chk("async rst full", 32'(ch_full), 32'd0);
    chk("async rst start", 32'(tx_start), 32'd0);
    chk("async rst data", 32'(tx_data), 32'd0);
    chk("async rst lost", 32'(start_lost), 32'd0);
    chk("async rst drop", 32'(drop_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; tx_busy = '0;
    nst = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (tx_start != '0) nst++;
      nextc();
    end
    chk("post rst no start", 32'(nst), 32'd0);

    // Out-of-range channel on a 3-channel instance.
    do_reset();
    v3 = 4'b0001; c3 = 8'h03; d3 = 32'h77;
    @(negedge clk);
    chk("drop ready", 32'(rdy3), 32'h1);
    chk("drop not yet", 32'(drop3), 32'd0);
    nextc();
    v3 = 4'b0010; c3 = 8'h08; d3 = 32'h9900;
    @(negedge clk);
    chk("drop pulse", 32'(drop3), 32'd1);
    chk("ch2 ready", 32'(rdy3), 32'h2);
    nextc();
    v3 = '0;
    @(negedge clk);
    chk("drop one cycle", 32'(drop3), 32'd0);
    chk("drop no start", 32'(st3), 32'd0);
    nextc();
    @(negedge clk);
    chk("ch2 start", 32'(st3), 32'h4);
    chk("ch2 data", 32'(dat3), 32'h990000);
    chk("drop no full", 32'(full3), 32'd0);
    nextc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
